// File: rtl/tern_pkg.sv
// Shared definitions for the ternary-to-binary serial converter.
//   - Trit encodings used on the sum/carry buses (2 bits per trit).
//   - FSM state type for the converter.
//   - trit_val(): maps a trit code to its numeric value, with the invalid code treated as 0.
package tern_pkg;

    localparam logic [1:0] TRIT_0   = 2'b00;
    localparam logic [1:0] TRIT_1   = 2'b01;
    localparam logic [1:0] TRIT_2   = 2'b10;
    localparam logic [1:0] TRIT_BAD = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    // The invalid code contributes nothing to the value. It is flagged separately.
    function automatic logic [1:0] trit_val(input logic [1:0] code);
        case (code)
            TRIT_1:  return 2'd1;
            TRIT_2:  return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/ternary_to_binary_serial_if.sv
// Handshake bundle between the ternary adder, the converter and the binary-domain consumer.
//   in_valid/in_ready   : input word handshake
//   in_sum              : TRITS trits, trit i at bits [2i+1:2i]
//   in_carry            : most-significant trit
//   out_valid/out_ready : result handshake
//   out_bin             : binary value of {in_carry, in_sum}
//   out_err             : set when any trit of the word was the invalid code
// Modports: master = producer/consumer side, slave = converter.
interface ternary_to_binary_serial_if #(
    parameter int TRITS = 8,
    parameter int BIN_W = 15
);
    logic               in_valid;
    logic               in_ready;
    logic [2*TRITS-1:0] in_sum;
    logic [1:0]         in_carry;
    logic               out_valid;
    logic               out_ready;
    logic [BIN_W-1:0]   out_bin;
    logic               out_err;

    modport master (
        output in_valid, in_sum, in_carry, out_ready,
        input  in_ready, out_valid, out_bin, out_err
    );

    modport slave (
        input  in_valid, in_sum, in_carry, out_ready,
        output in_ready, out_valid, out_bin, out_err
    );
endinterface

// File: rtl/tern_mac3.sv
// Combinational Horner step: res = acc*3 + trit, computed in BIN_W bits.
// Ports:
//   acc   : running accumulator
//   trit  : trit code (2 bits)
//   res   : acc*3 + value(trit)
//   bad   : trit is the invalid code (which then contributes 0)
module tern_mac3
    import tern_pkg::*;
#(
    parameter int BIN_W = 15
) (
    input  logic [BIN_W-1:0] acc,
    input  logic [1:0]       trit,
    output logic [BIN_W-1:0] res,
    output logic             bad
);
    // acc*3 as shift-and-add. The width constraint on BIN_W rules out overflow.
    assign res = (acc << 1) + acc + BIN_W'(trit_val(trit));
    assign bad = (trit == TRIT_BAD);
endmodule

// File: rtl/ternary_to_binary_serial.sv
// Serial ternary-to-binary converter: takes a (TRITS+1)-trit unsigned word
// {in_carry, in_sum} and produces its binary value MSB-first by Horner
// iteration, one trit per clock.
// Ports:
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : ternary_to_binary_serial_if.slave (in/out valid-ready handshakes)
// Build option: TERN_CONV_ZERO_SKIP_EN -- an all-zero word bypasses CONV and
//   the result is presented right after the acceptance edge.
module ternary_to_binary_serial
    import tern_pkg::*;
#(
    parameter int TRITS = 8,
    parameter int BIN_W = 15
) (
    input  logic                          clk,
    input  logic                          rst,
    ternary_to_binary_serial_if.slave     bus
);
    localparam int SH_W  = 2 * (TRITS + 1);
    localparam int CNT_W = $clog2(TRITS + 1);

    state_t           state_reg,   state_next;
    logic [SH_W-1:0]  shift_reg,   shift_next;
    logic [BIN_W-1:0] acc_reg,     acc_next;
    logic [CNT_W-1:0] cnt_reg,     cnt_next;
    logic             err_reg,     err_next;
    logic [BIN_W-1:0] out_bin_reg, out_bin_next;
    logic             out_err_reg, out_err_next;

    logic [BIN_W-1:0] mac_res;
    logic             mac_bad;

    // The current trit is always the top pair of the shift register.
    tern_mac3 #(.BIN_W(BIN_W)) u_mac (
        .acc  (acc_reg),
        .trit (shift_reg[SH_W-1 -: 2]),
        .res  (mac_res),
        .bad  (mac_bad)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            shift_reg   <= '0;
            acc_reg     <= '0;
            cnt_reg     <= '0;
            err_reg     <= 1'b0;
            out_bin_reg <= '0;
            out_err_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            shift_reg   <= shift_next;
            acc_reg     <= acc_next;
            cnt_reg     <= cnt_next;
            err_reg     <= err_next;
            out_bin_reg <= out_bin_next;
            out_err_reg <= out_err_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        shift_next   = shift_reg;
        acc_next     = acc_reg;
        cnt_next     = cnt_reg;
        err_next     = err_reg;
        out_bin_next = out_bin_reg;
        out_err_next = out_err_reg;

        case (state_reg)
            IDLE: begin
                if (bus.in_valid) begin
                    shift_next = {bus.in_carry, bus.in_sum};
                    acc_next   = '0;
                    err_next   = 1'b0;
                    cnt_next   = CNT_W'(TRITS);
                    state_next = CONV;
`ifdef TERN_CONV_ZERO_SKIP_EN
                    if ({bus.in_carry, bus.in_sum} == '0) begin
                        state_next   = DONE;
                        out_bin_next = '0;
                        out_err_next = 1'b0;
                    end
`endif
                end
            end
            CONV: begin
                acc_next   = mac_res;
                shift_next = {shift_reg[SH_W-3:0], 2'b00};
                cnt_next   = cnt_reg - CNT_W'(1);
                err_next   = err_reg | mac_bad;
                // Counter counts TRITS..0, so the zero step handles the last (LSB) trit.
                if (cnt_reg == '0) begin
                    state_next   = DONE;
                    out_bin_next = mac_res;
                    out_err_next = err_reg | mac_bad;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.in_ready  = (state_reg == IDLE);
    assign bus.out_valid = (state_reg == DONE);
    assign bus.out_bin   = out_bin_reg;
    assign bus.out_err   = out_err_reg;

endmodule

// File: tb/tb_ternary_to_binary_serial.sv
// Directed bench for ternary_to_binary_serial with hand-computed expected values.
module tb_ternary_to_binary_serial;
    localparam int TRITS = 8;
    localparam int BIN_W = 15;
`ifdef TERN_CONV_ZERO_SKIP_EN
    localparam int ZERO_LAT = 0;
`else
    localparam int ZERO_LAT = 9;
`endif
    localparam int TIMEOUT = 50;

    logic clk;
    logic rst;
    int   checks;
    int   fails;

    ternary_to_binary_serial_if #(.TRITS(TRITS), .BIN_W(BIN_W)) bus ();

    ternary_to_binary_serial #(.TRITS(TRITS), .BIN_W(BIN_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present a word and hold it for exactly one acceptance edge (E0).
    task automatic start_word(input logic [1:0] carry, input logic [15:0] sum);
        int n;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < TIMEOUT) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= TIMEOUT) begin
            checks++; fails++;
            $display("FAIL start_timeout: in_ready=%b required 1", bus.in_ready);
        end
        bus.in_carry = carry;
        bus.in_sum   = sum;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    // Edges after E0 until out_valid is seen.
    task automatic wait_done(output int lat);
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < TIMEOUT) begin
            @(posedge clk); #1;
            lat++;
        end
        if (lat >= TIMEOUT) begin
            checks++; fails++;
            $display("FAIL done_timeout: out_valid=%b required 1", bus.out_valid);
        end
    endtask

    task automatic finish_word();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b required 1", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b required 0", bus.out_valid); end
        checks++; if (bus.out_bin !== 15'd0) begin fails++; $display("FAIL reset_out_bin: got %0d required 0", bus.out_bin); end
        checks++; if (bus.out_err !== 1'b0) begin fails++; $display("FAIL reset_out_err: got %b required 0", bus.out_err); end
        rst = 1'b0;
        $display("txn reset released");
    endtask

    task automatic test_values();
        logic [1:0]  carry_t [6];
        logic [15:0] sum_t   [6];
        logic [14:0] bin_t   [6];
        logic        err_t   [6];
        int lat;
        carry_t = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b00, 2'b00};
        sum_t   = '{16'h0001, 16'hAAAA, 16'h0000, 16'hAAAA, 16'h0024, 16'h4000};
        bin_t   = '{15'd1, 15'd6560, 15'd6561, 15'd19682, 15'd21, 15'd2187};
        err_t   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 6; i++) begin
            start_word(carry_t[i], sum_t[i]);
            wait_done(lat);
            $display("txn carry=%b sum=%h bin=%0d err=%b lat=%0d", carry_t[i], sum_t[i], bus.out_bin, bus.out_err, lat);
            checks++; if (bus.out_bin !== bin_t[i]) begin fails++; $display("FAIL value_bin[%0d]: got %0d required %0d", i, bus.out_bin, bin_t[i]); end
            checks++; if (bus.out_err !== err_t[i]) begin fails++; $display("FAIL value_err[%0d]: got %b required %b", i, bus.out_err, err_t[i]); end
            checks++; if (lat != 9) begin fails++; $display("FAIL value_latency[%0d]: got %0d required 9", i, lat); end
            checks++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL value_in_ready[%0d]: got %b required 0", i, bus.in_ready); end
            finish_word();
        end
    endtask

    task automatic test_invalid();
        int lat;
        start_word(2'b00, 16'h0003);
        wait_done(lat);
        $display("txn carry=00 sum=0003 bin=%0d err=%b lat=%0d", bus.out_bin, bus.out_err, lat);
        checks++; if (bus.out_bin !== 15'd0) begin fails++; $display("FAIL invalid_bin: got %0d required 0", bus.out_bin); end
        checks++; if (bus.out_err !== 1'b1) begin fails++; $display("FAIL invalid_err: got %b required 1", bus.out_err); end
        finish_word();
        start_word(2'b00, 16'h0001);
        wait_done(lat);
        $display("txn carry=00 sum=0001 bin=%0d err=%b lat=%0d", bus.out_bin, bus.out_err, lat);
        checks++; if (bus.out_err !== 1'b0) begin fails++; $display("FAIL invalid_clear_err: got %b required 0", bus.out_err); end
        checks++; if (bus.out_bin !== 15'd1) begin fails++; $display("FAIL invalid_next_bin: got %0d required 1", bus.out_bin); end
        finish_word();
    endtask

    task automatic test_hold();
        int lat;
        start_word(2'b00, 16'h0024);
        wait_done(lat);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = ~bus.in_valid;
            bus.in_sum   = 16'h1111;
            bus.in_carry = 2'b01;
            @(posedge clk); #1;
            checks++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL hold_valid[%0d]: got %b required 1", i, bus.out_valid); end
            checks++; if (bus.out_bin !== 15'd21) begin fails++; $display("FAIL hold_bin[%0d]: got %0d required 21", i, bus.out_bin); end
            checks++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL hold_in_ready[%0d]: got %b required 0", i, bus.in_ready); end
        end
        bus.in_valid = 1'b0;
        $display("txn hold carry=00 sum=0024 bin=%0d held 5 cycles", bus.out_bin);
        finish_word();
        checks++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL hold_release_ready: got %b required 1", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL hold_release_valid: got %b required 0", bus.out_valid); end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL hold_no_new_word[%0d]: got %b required 0", i, bus.out_valid); end
        end
    endtask

    task automatic test_reset_mid();
        start_word(2'b00, 16'hAAAA);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        $display("txn reset during CONV: valid=%b ready=%b bin=%0d", bus.out_valid, bus.in_ready, bus.out_bin);
        checks++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL midreset_valid: got %b required 0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL midreset_ready: got %b required 1", bus.in_ready); end
        checks++; if (bus.out_bin !== 15'd0) begin fails++; $display("FAIL midreset_bin: got %0d required 0", bus.out_bin); end
        checks++; if (bus.out_err !== 1'b0) begin fails++; $display("FAIL midreset_err: got %b required 0", bus.out_err); end
    endtask

    task automatic test_zero();
        int lat;
        start_word(2'b00, 16'h0000);
        wait_done(lat);
        $display("txn carry=00 sum=0000 bin=%0d err=%b lat=%0d", bus.out_bin, bus.out_err, lat);
        checks++; if (lat != ZERO_LAT) begin fails++; $display("FAIL zero_latency: got %0d required %0d", lat, ZERO_LAT); end
        checks++; if (bus.out_bin !== 15'd0) begin fails++; $display("FAIL zero_bin: got %0d required 0", bus.out_bin); end
        checks++; if (bus.out_err !== 1'b0) begin fails++; $display("FAIL zero_err: got %b required 0", bus.out_err); end
        finish_word();
    endtask

    initial begin
        checks        = 0;
        fails         = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_sum    = '0;
        bus.in_carry  = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_values();
        test_invalid();
        test_hold();
        test_reset_mid();
        test_zero();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
